// File: rtl/uart_byte_receiver_if.sv
// Byte-side bundle between the UART receiver and the command decoder.
interface uart_byte_receiver_if;
    logic [7:0] byte_out;
    logic       byte_ready;
    logic       frame_error;
    logic       busy;

    modport master (output byte_out, output byte_ready, output frame_error, output busy);
    modport slave  (input  byte_out, input  byte_ready, input  frame_error, input  busy);
endinterface

// File: rtl/uart_byte_receiver.sv
// Oversampling 8N1 UART receiver: synchronizes rx, deframes one character and
// presents each good byte with a single-cycle ready strobe.
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    uart_byte_receiver_if.master  rx_bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_out_q, byte_out_d;
    logic                   ready_q, ready_d;
    logic                   ferr_q, ferr_d;
    logic                   armed_q, armed_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   busy_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // State and datapath registers, including the rx synchronizer chain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            byte_out_q <= 8'h00;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
            armed_q    <= 1'b0;
            sync_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_out_q <= byte_out_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
            armed_q    <= armed_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    // Next-state and clock-counter logic; the counter clears on every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = (bit_idx_q == 3'd7) ? STOP : DATA;
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = CLEANUP;
                end else begin
                    state_d = STOP;
                end
            end
            CLEANUP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Shift register, output byte, strobes and the re-arm flag that blocks a held-low line.
    always_comb begin
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_out_d = byte_out_q;
        ready_d    = 1'b0;
        ferr_d     = 1'b0;
        armed_d    = armed_q;
        busy_s     = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                bit_idx_d = 3'd0;
                armed_d   = armed_q | rx_s;
            end
            START: begin
                bit_idx_d = 3'd0;
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    shift_d = shift_q;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    if (rx_s) begin
                        byte_out_d = shift_q;
                        ready_d    = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    ready_d = 1'b0;
                end
            end
            CLEANUP: begin
                armed_d = rx_s;
            end
            default: begin
                armed_d = 1'b0;
            end
        endcase
    end

    assign rx_bus.byte_out    = byte_out_q;
    assign rx_bus.byte_ready  = ready_q;
    assign rx_bus.frame_error = ferr_q;
    assign rx_bus.busy        = busy_s;

endmodule

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
- Serial front end of the analyzer's host command path.
- Oversamples the asynchronous host UART RX line, deframes 8N1 characters and presents each byte with a ready strobe.
- Its output drives the command decoder's byte_in / byte_in_ready inputs. One byte_ready pulse per good frame, with byte_out stable until the next good frame, gives exactly one decoder byte per frame.
- Frames with a bad start or stop bit never produce byte_ready.

Parameters:
- CLKS_PER_BIT, 868, system clocks per UART bit (100 MHz / 115200). Legal range is 4..65535.
- SYNC_STAGES, 2, flip-flop depth of the rx synchronizer. Legal range is 2..4.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising clock edge; reset==0 resets the block.
- rx  input  1  asynchronous serial line; idle high.
- byte_out  output  8  last correctly received byte.
- byte_ready  output  1  one-cycle strobe; byte_out is valid in the same cycle.
- frame_error  output  1  one-cycle strobe; the stop bit was sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, bit counter=0, clock counter=0.
  - byte_out=8'h00, byte_ready=0, frame_error=0, busy=0.
  - Synchronizer flops preset to 1 (line idle).
  - Reset asserted mid-frame aborts the frame with no strobe. After release, reception restarts only on a fresh falling edge.
- Synchronizer: rx passes through SYNC_STAGES flops; rx_s is the last stage. All decisions use rx_s only.
- Clock counter: width clog2(CLKS_PER_BIT). Clears on every state change.
- FSM states:
  - IDLE: when rx_s==0, go to START with the clock counter cleared.
  - START: count to (CLKS_PER_BIT-1)/2 (integer division).
    - At that count, rx_s==0: go to DATA with bit index 0.
    - At that count, rx_s==1: glitch; return to IDLE with no strobe.
  - DATA: at count CLKS_PER_BIT-1, shift rx_s into the shift register, LSB first (bit index k lands in bit k).
    - Index 7 done: go to STOP.
    - Otherwise: increment the index.
  - STOP: at count CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: byte_out <= shift register, byte_ready=1 for exactly the next cycle.
    - rx_s==0: byte_out unchanged, frame_error=1 for exactly the next cycle.
    - Either case: go to CLEANUP.
  - CLEANUP: one cycle; strobes deassert; go to IDLE.
    - If rx_s==1, the next frame is accepted from the following cycle.
    - If rx_s==0 (break / stuck-low line after an error), IDLE re-arms only after rx_s has been seen high for at least one cycle. No strobes while the line is held low.
- Timing:
  - Sampling points sit at mid-bit.
  - Latency from the rx start edge to byte_ready is SYNC_STAGES + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 cycles, ±1.
- Strobe rules:
  - byte_ready and frame_error are never high together.
  - Strobes are at least 10*CLKS_PER_BIT cycles apart, so the decoder always sees ready low between bytes.
- busy is combinational from state; it is high from START through CLEANUP inclusive.
- byte_out holds its value indefinitely between frames. It changes only in the same cycle that byte_ready rises.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2):
- Reset, then one idle-high frame for 0xA5 -> byte_out=8'hA5 with a single byte_ready pulse; frame_error stays 0; busy returns to 0.
- Back-to-back frames 0x01, 0x00, 0x00, 0x00, 0x10 (decoder command sequence) with no idle gap -> five byte_ready pulses carrying those values in order; none lost or duplicated.
- rx low for only 5 clocks, then high -> no strobe; FSM back in IDLE within 8 cycles; a following 0x3C frame is received correctly.
- Frame 0x55 with the stop bit driven low, rx then held low for 200 clocks -> one frame_error pulse; byte_out keeps its previous value; no further strobes until rx returns high; a next 0xC3 frame is received.
- reset driven low during data bit 4 of 0xFF, released for 1 cycle, then a 0x81 frame -> no strobe for the aborted frame; byte_out=8'h81 afterwards.
- Baud tolerance: 0x5A sent at ±3% bit period -> received as 0x5A in both cases.
